// File: rtl/barrett_pkg.sv
// Shared helpers for the pipelined Barrett reducer: reduction constant and
// result width, both evaluated at elaboration time from the modulus.
package barrett_pkg;

  // Barrett multiplier M = floor(2^k / q); wide enough for any practical k.
  function automatic logic [127:0] barrett_m(input int unsigned q, input int unsigned k);
    return (128'd1 << k) / 128'(q);
  endfunction

  // Number of bits needed to hold a residue in [0, q-1].
  function automatic int barrett_out_w(input int unsigned q);
    return $clog2(q);
  endfunction

endpackage

// File: rtl/barrett_csub.sv
// Final reduction stage: registered conditional subtract taking a partial
// remainder in [0, 2Q) to the canonical range [0, Q).
// Optional tag sideband under BARRETT_TAG_EN.
module barrett_csub #(
  parameter int Q     = 3329,
  parameter int OUT_W = 12
`ifdef BARRETT_TAG_EN
  , parameter int TAG_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [OUT_W:0]   in_r,
`ifdef BARRETT_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  localparam int              R_W = OUT_W + 1;
  localparam logic [R_W-1:0]  Q_R = R_W'(Q);

  // Output register: subtract Q once when needed, hold while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef BARRETT_TAG_EN
      out_tag   <= '0;
`endif
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= (in_r >= Q_R) ? OUT_W'(in_r - Q_R) : OUT_W'(in_r);
`ifdef BARRETT_TAG_EN
      out_tag   <= in_tag;
`endif
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Four-stage pipelined Barrett reducer: out_data = in_data mod Q.
// S1 captures x, S2 forms the quotient estimate t, S3 the partial remainder
// on the low OUT_W+1 bits, S4 (barrett_csub) the final correction.
// The whole pipe advances together whenever the output slot is free or
// being drained, so one result per cycle flows when unstalled.
// Optional feature macro: BARRETT_TAG_EN adds an in_tag/out_tag sideband
// that travels in lock-step with its data word.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter  int Q     = 3329,
  parameter  int IN_W  = 32,
  parameter  int K     = IN_W,
  parameter  int TAG_W = 8,
  localparam int OUT_W = barrett_out_w(Q)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
`ifdef BARRETT_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam logic [127:0]    M_FULL = barrett_m(Q, K);
  localparam int              M_W    = $clog2(M_FULL + 128'd1);
  localparam logic [M_W-1:0]  M      = M_W'(M_FULL);
  localparam int              P_W    = IN_W + M_W;
  localparam int              T_W    = IN_W - OUT_W + 1;
  localparam int              R_W    = OUT_W + 1;
  localparam logic [R_W-1:0]  Q_R    = R_W'(Q);

  // Reject configurations where a single correction is not guaranteed.
  generate
    if (K < IN_W || (Q % 2) == 0 || Q < 3 ||
        64'(Q) >= (64'd1 << (IN_W - 1)) || TAG_W < 1) begin : g_bad_cfg
      $error("barrett_reduce_pipe: illegal Q/IN_W/K/TAG_W combination");
    end
  endgenerate

  logic             adv;
  logic             v1, v2, v3;
  logic [IN_W-1:0]  x1;
  logic [R_W-1:0]   x2;
  logic [T_W-1:0]   t2;
  logic [R_W-1:0]   r3;
  logic [P_W-1:0]   prod;

  // Only the output slot can block; everything upstream moves with it.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Quotient estimate; t < 2^T_W because x < 2^IN_W and Q >= 2^(OUT_W-1).
  assign prod = P_W'(x1) * P_W'(M);

  // Stages S1..S3: shift on advance, hold otherwise; invalid slots ride along as bubbles.
  always_ff @(posedge clk) begin
    // NOTE: every register here is assigned with <= so all stages sample the
    // previous cycle's values; a blocking = would let a word skip stages.
    if (rst) begin
      // NOTE: datapath registers are cleared too, not only the valids, so that
      // the outputs read zero after reset and simulation never carries X.
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      x1 <= '0;
      x2 <= '0;
      t2 <= '0;
      r3 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      x1 <= in_data;
      v2 <= v1;
      x2 <= R_W'(x1);
      t2 <= T_W'(prod >> K);
      v3 <= v2;
      // r = x - t*Q lies in [0, 2Q), so OUT_W+1 low bits are exact.
      r3 <= x2 - R_W'(t2) * Q_R;
    end
  end

`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0] tag1, tag2, tag3;

  // Tag sideband mirrors the data stages exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
    end else if (adv) begin
      tag1 <= in_tag;
      tag2 <= tag1;
      tag3 <= tag2;
    end
  end
`endif

  barrett_csub #(
    .Q     (Q),
    .OUT_W (OUT_W)
`ifdef BARRETT_TAG_EN
    , .TAG_W (TAG_W)
`endif
  ) u_csub (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .in_valid  (v3),
    .in_r      (r3),
`ifdef BARRETT_TAG_EN
    .in_tag    (tag3),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe: scoreboard queues hold the
// expected residue (computed with the % operator) for every accepted word.
// Instance A: Q=3329, IN_W=32. Instance B: Q=7681, IN_W=28.
// Tag comparisons are active when BARRETT_TAG_EN is defined.
module tb_barrett_reduce_pipe;

  localparam int A_Q = 3329;
  localparam int B_Q = 7681;

  typedef struct {
    logic [31:0] x;
    logic [12:0] res;
    logic [7:0]  tag;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [31:0] a_in_data = '0;
  logic [11:0] a_out_data;
  logic [7:0]  a_in_tag = '0, a_out_tag;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [27:0] b_in_data = '0;
  logic [12:0] b_out_data;
  logic [7:0]  b_in_tag = '0, b_out_tag;

  exp_t        a_q[$];
  exp_t        b_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          a_in_cnt = 0, a_out_cnt = 0;
  int          b_in_cnt = 0, b_out_cnt = 0;
  bit          a_lat_chk = 1'b0;
  bit          a_hold_prev = 1'b0;
  logic [11:0] a_hold_data = '0;
  logic [7:0]  a_hold_tag = '0;

  always #5 clk = ~clk;

`ifndef BARRETT_TAG_EN
  assign a_out_tag = '0;
  assign b_out_tag = '0;
`endif

  barrett_reduce_pipe #(.Q(A_Q), .IN_W(32)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
`ifdef BARRETT_TAG_EN
    .in_tag    (a_in_tag),
    .out_tag   (a_out_tag),
`endif
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data)
  );

  barrett_reduce_pipe #(.Q(B_Q), .IN_W(28)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
`ifdef BARRETT_TAG_EN
    .in_tag    (b_in_tag),
    .out_tag   (b_out_tag),
`endif
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
  );

  // One cycle on instance A: drive at negedge, sample 1ns later, then wait.
  task automatic step_a(input logic v, input logic [31:0] d, input logic [7:0] tg,
                        input logic rdy, output bit acc);
    exp_t e;
    a_in_valid  = v;
    a_in_data   = d;
    a_in_tag    = tg;
    a_out_ready = rdy;
    acc = 1'b0;
    #1;
    if (!rst) begin
      if (a_hold_prev) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== a_hold_data || a_out_tag !== a_hold_tag) begin
          errors++;
          $display("FAIL a_stall_stable: got v=%0b d=%0d t=%0d required v=1 d=%0d t=%0d",
                   a_out_valid, a_out_data, a_out_tag, a_hold_data, a_hold_tag);
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready === 1'b0) begin
        checks++;
        if (a_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL a_in_ready_stall: got %0b required 0", a_in_ready);
        end
      end
      a_hold_prev = (a_out_valid === 1'b1) && !a_out_ready;
      a_hold_data = a_out_data;
      a_hold_tag  = a_out_tag;
      if (a_in_valid && a_in_ready === 1'b1) begin
        e.x = d; e.res = 13'(d % 32'(A_Q)); e.tag = tg; e.stamp = cyc;
        a_q.push_back(e);
        a_in_cnt++;
        acc = 1'b1;
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        checks++;
        if (a_q.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_out: got d=%0d required no output", a_out_data);
        end else begin
          e = a_q.pop_front();
          a_out_cnt++;
          if ({1'b0, a_out_data} !== e.res) begin
            errors++;
            $display("FAIL a_data: x=%0d got %0d required %0d", e.x, a_out_data, e.res);
          end
`ifdef BARRETT_TAG_EN
          checks++;
          if (a_out_tag !== e.tag) begin
            errors++;
            $display("FAIL a_tag: x=%0d got %0d required %0d", e.x, a_out_tag, e.tag);
          end
`endif
          if (a_lat_chk) begin
            checks++;
            if (cyc - e.stamp != 4) begin
              errors++;
              $display("FAIL a_latency: x=%0d got %0d required 4", e.x, cyc - e.stamp);
            end
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // One cycle on instance B (scoreboard only).
  task automatic step_b(input logic v, input logic [27:0] d, input logic [7:0] tg,
                        input logic rdy, output bit acc);
    exp_t e;
    b_in_valid  = v;
    b_in_data   = d;
    b_in_tag    = tg;
    b_out_ready = rdy;
    acc = 1'b0;
    #1;
    if (b_in_valid && b_in_ready === 1'b1) begin
      e.x = 32'(d); e.res = 13'(32'(d) % 32'(B_Q)); e.tag = tg; e.stamp = cyc;
      b_q.push_back(e);
      b_in_cnt++;
      acc = 1'b1;
    end
    if (b_out_valid === 1'b1 && b_out_ready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_out: got d=%0d required no output", b_out_data);
      end else begin
        e = b_q.pop_front();
        b_out_cnt++;
        if (b_out_data !== e.res) begin
          errors++;
          $display("FAIL b_data: x=%0d got %0d required %0d", e.x, b_out_data, e.res);
        end
`ifdef BARRETT_TAG_EN
        checks++;
        if (b_out_tag !== e.tag) begin
          errors++;
          $display("FAIL b_tag: x=%0d got %0d required %0d", e.x, b_out_tag, e.tag);
        end
`endif
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain_a();
    bit acc;
    int budget = 0;
    while (a_q.size() != 0 && budget < 200) begin
      step_a(1'b0, '0, '0, 1'b1, acc);
      budget++;
    end
    checks++;
    if (a_q.size() != 0 || a_in_cnt != a_out_cnt) begin
      errors++;
      $display("FAIL a_drain: got in=%0d out=%0d pending=%0d required equal counts, 0 pending",
               a_in_cnt, a_out_cnt, a_q.size());
    end
  endtask

  task automatic drain_b();
    bit acc;
    int budget = 0;
    while (b_q.size() != 0 && budget < 200) begin
      step_b(1'b0, '0, '0, 1'b1, acc);
      budget++;
    end
    checks++;
    if (b_q.size() != 0 || b_in_cnt != b_out_cnt) begin
      errors++;
      $display("FAIL b_drain: got in=%0d out=%0d pending=%0d required equal counts, 0 pending",
               b_in_cnt, b_out_cnt, b_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 12'd0 || a_out_tag !== 8'd0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_a: got ov=%0b od=%0d ot=%0d ir=%0b required 0 0 0 1",
               a_out_valid, a_out_data, a_out_tag, a_in_ready);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 13'd0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_b: got ov=%0b od=%0d ir=%0b required 0 0 1",
               b_out_valid, b_out_data, b_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [4];
    bit acc;
    xs[0] = 32'd0; xs[1] = 32'd3328; xs[2] = 32'd3329; xs[3] = 32'd6657;
    a_lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) step_a(1'b1, xs[i], 8'(i), 1'b1, acc);
    drain_a();
    a_lat_chk = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [31:0] xs [4];
    bit acc;
    xs[0] = 32'hFFFF_FFFF; xs[1] = 32'hFFFF_FFFE; xs[2] = 32'h8000_0000; xs[3] = 32'd3328 * 32'd1000;
    a_lat_chk = 1'b1;
    step_a(1'b1, xs[0], 8'hA5, 1'b1, acc);
    repeat (3) step_a(1'b0, '0, '0, 1'b1, acc);
    #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'd1352) begin
      errors++;
      $display("FAIL a_max_input: got v=%0b d=%0d required v=1 d=1352", a_out_valid, a_out_data);
    end
    for (int i = 1; i < 4; i++) step_a(1'b1, xs[i], 8'(i), 1'b1, acc);
    drain_a();
    a_lat_chk = 1'b0;
  endtask

  task automatic test_stall();
    bit acc;
    int i = 0;
    int s = 0;
    while ((i < 8 || s < 12) && s < 200) begin
      step_a(i < 8, 32'd1000 + 32'(i) * 32'd777, 8'(8'h40 + i), !(s >= 5 && s < 10), acc);
      if (acc) i++;
      s++;
    end
    drain_a();
  endtask

  task automatic test_reset_mid();
    bit acc;
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'd5000 + 32'(i), 8'(i), 1'b1, acc);
    rst = 1'b1;
    step_a(1'b0, '0, '0, 1'b1, acc);
    rst = 1'b0;
    a_q.delete();
    a_in_cnt  = 0;
    a_out_cnt = 0;
    a_hold_prev = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 12'd0) begin
      errors++;
      $display("FAIL a_reset_mid: got v=%0b d=%0d required v=0 d=0", a_out_valid, a_out_data);
    end
    repeat (8) step_a(1'b0, '0, '0, 1'b1, acc);
    checks++;
    if (a_out_cnt != 0) begin
      errors++;
      $display("FAIL a_flushed_words: got %0d outputs required 0", a_out_cnt);
    end
  endtask

  task automatic test_random();
    bit acc;
    int sent = 0;
    int budget = 0;
    while (sent < 10000 && budget < 60000) begin
      step_a($urandom_range(0, 3) != 0, $urandom(), 8'(sent), $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      budget++;
    end
    checks++;
    if (sent != 10000) begin
      errors++;
      $display("FAIL a_random_budget: got %0d words required 10000", sent);
    end
    drain_a();
  endtask

  task automatic test_second_modulus();
    bit acc;
    int sent = 0;
    int budget = 0;
    step_b(1'b1, 28'h0FF_FFFF, 8'hEE, 1'b1, acc);
    step_b(1'b1, 28'hFFF_FFFF, 8'hEF, 1'b1, acc);
    step_b(1'b1, 28'd7680, 8'hF0, 1'b1, acc);
    step_b(1'b1, 28'd7681, 8'hF1, 1'b1, acc);
    while (sent < 600 && budget < 5000) begin
      step_b($urandom_range(0, 3) != 0, 28'($urandom()), 8'(sent), $urandom_range(0, 2) != 0, acc);
      if (acc) sent++;
      budget++;
    end
    drain_b();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_boundaries();
    test_stall();
    test_reset_mid();
    test_random();
    test_second_modulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
